// File: rtl/cafe_order_scheduler.sv
// Round-robin order scheduler in front of the coffee-machine FSM: queues one order per requester,
// handshakes start/ack on machine_state and watches for timeouts. Define CAFE_FIXED_PRIO_EN for fixed priority.
module cafe_order_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int BREW_TIMEOUT = 255,
    parameter int CNT_W        = 8,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               clear_err,
    input  logic [3:0]         machine_state,
    output logic               start,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] done,
    output logic               error,
    output logic [CNT_W-1:0]   cups_served
);

    localparam int TMR_MAX = (BREW_TIMEOUT > ACK_TIMEOUT) ? BREW_TIMEOUT : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [3:0] MS_IDLE    = 4'd1;
    localparam logic [3:0] MS_EXTRACT = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_BREWING,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ID_W-1:0]      r_grant_id;
    logic [NUM_REQ-1:0]   r_pending;
    logic                 r_error;
    logic [CNT_W-1:0]     r_cups;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_saw_extract;

    logic                 w_sel_found;
    logic [ID_W-1:0]      w_sel_id;
    logic [NUM_REQ-1:0]   w_grant_onehot;
    logic                 w_acked;
    logic                 w_ack_expired;
    logic                 w_brew_expired;
    logic                 w_start;
    logic                 w_busy;
    logic [NUM_REQ-1:0]   w_done;

`ifdef CAFE_FIXED_PRIO_EN
    // Lowest pending index wins; scanning downward leaves the lowest one selected.
    always_comb begin
        w_sel_found = |r_pending;
        w_sel_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] r_last_grant;
    logic [ID_W-1:0] w_idx;

    // Search upward from the requester after the last one served, wrapping at NUM_REQ.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_sel_found && r_pending[w_idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (r_state == S_DONE) begin
            r_last_grant <= r_grant_id;
        end
    end
`endif

    assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;
    assign w_acked        = (r_state == S_WAIT_ACK) && (machine_state != MS_IDLE);
    assign w_ack_expired  = (r_timer == TMR_W'(ACK_TIMEOUT - 1));
    assign w_brew_expired = (r_timer == TMR_W'(BREW_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_start      = 1'b0;
        w_busy       = 1'b1;
        w_done       = '0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_sel_found) begin
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                w_start = 1'b1;
                if (machine_state != MS_IDLE) begin
                    w_state_next = S_BREWING;
                end else if (w_ack_expired) begin
                    w_state_next = S_ERROR;
                end
            end
            S_BREWING: begin
                if (machine_state == MS_IDLE && r_saw_extract) begin
                    w_state_next = S_DONE;
                end else if (w_brew_expired) begin
                    w_state_next = S_ERROR;
                end
            end
            S_DONE: begin
                w_done       = w_grant_onehot;
                w_state_next = S_IDLE;
            end
            S_ERROR: begin
                if (clear_err) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id    <= '0;
            r_pending     <= '0;
            r_error       <= 1'b0;
            r_cups        <= '0;
            r_timer       <= '0;
            r_saw_extract <= 1'b0;
        end else begin
            // A request arriving on the same edge as the acceptance clear re-queues the order.
            r_pending <= (r_pending & ~(w_acked ? w_grant_onehot : '0)) | req;

            case (r_state)
                S_IDLE: begin
                    if (w_sel_found) begin
                        r_grant_id <= w_sel_id;
                        r_timer    <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_acked) begin
                        r_timer       <= '0;
                        r_saw_extract <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_BREWING: begin
                    r_timer <= r_timer + 1'b1;
                    if (machine_state == MS_EXTRACT) begin
                        r_saw_extract <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_cups != '1) begin
                        r_cups <= r_cups + 1'b1;
                    end
                end
                S_ERROR: begin
                    if (clear_err) begin
                        r_error <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (w_state_next == S_ERROR && r_state != S_ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign start       = w_start;
    assign busy        = w_busy;
    assign done        = w_done;
    assign grant_id    = r_grant_id;
    assign pending     = r_pending;
    assign error       = r_error;
    assign cups_served = r_cups;

endmodule

// File: tb/tb_cafe_order_scheduler.sv
// Directed bench for cafe_order_scheduler: drives machine_state by hand and checks grants, done pulses,
// counters, timeouts and async reset. A CNT_W=2 copy checks counter saturation.
module tb_cafe_order_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       clear_err;
    logic [3:0] machine_state;

    logic       start, busy, error;
    logic [1:0] grant_id;
    logic [3:0] pending, done;
    logic [7:0] cups_served;

    logic       sat_start, sat_busy, sat_error;
    logic [1:0] sat_grant_id;
    logic [3:0] sat_pending, sat_done;
    logic [1:0] sat_cups;

    int n_total = 0;
    int n_bad   = 0;

`ifdef CAFE_FIXED_PRIO_EN
    int         exp_g[4] = '{0, 0, 1, 3};
    logic [3:0] exp_p[4] = '{4'b1010, 4'b1010, 4'b1000, 4'b0000};
`else
    int         exp_g[4] = '{0, 1, 3, 0};
    logic [3:0] exp_p[4] = '{4'b1010, 4'b1001, 4'b0001, 4'b0000};
`endif

    cafe_order_scheduler #(
        .NUM_REQ(4), .ACK_TIMEOUT(16), .BREW_TIMEOUT(255), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .clear_err(clear_err),
        .machine_state(machine_state), .start(start), .busy(busy),
        .grant_id(grant_id), .pending(pending), .done(done),
        .error(error), .cups_served(cups_served)
    );

    cafe_order_scheduler #(
        .NUM_REQ(4), .ACK_TIMEOUT(16), .BREW_TIMEOUT(255), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req), .clear_err(clear_err),
        .machine_state(machine_state), .start(sat_start), .busy(sat_busy),
        .grant_id(sat_grant_id), .pending(sat_pending), .done(sat_done),
        .error(sat_error), .cups_served(sat_cups)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        req           = '0;
        clear_err     = 1'b0;
        machine_state = 4'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_start(input int max_cyc);
        int n = 0;
        while (start !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("wait_start", start, 1);
    endtask

    // Called on the negedge where start is seen; returns on the negedge where done should be high.
    task automatic run_brew(input logic [3:0] req_ack, input logic [3:0] req_mid,
                            input logic [3:0] exp_pend);
        logic [3:0] seq[6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
        machine_state = 4'd2;
        req           = req_ack;
        @(negedge clk);
        req = '0;
        check("start_one_cycle", start, 0);
        check("pending_after_ack", pending, exp_pend);
        machine_state = 4'd3;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            machine_state = seq[s];
            req = (seq[s] == 4'd6) ? req_mid : 4'b0000;
        end
        @(negedge clk);
        req = '0;
    endtask

    initial begin
        logic [3:0] done_seen;
        rst_n         = 1'b0;
        req           = '0;
        clear_err     = 1'b0;
        machine_state = 4'd1;

        // Reset state
        apply_reset();
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_pending", pending, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cups", cups_served, 0);

        // Single order
        pulse_req(4'b0001);
        check("single_pending", pending, 4'b0001);
        check("single_idle_busy", busy, 0);
        wait_start(5);
        check("single_grant", grant_id, 0);
        run_brew(4'b0000, 4'b0000, 4'b0000);
        check("single_done", done, 4'b0001);
        check("single_cups_before", cups_served, 0);
        @(negedge clk);
        check("single_done_once", done, 0);
        check("single_cups", cups_served, 1);
        check("single_busy_end", busy, 0);

        // Round-robin with requester 0 re-ordering during the first brew
        apply_reset();
        pulse_req(4'b1011);
        for (int r = 0; r < 4; r++) begin
            wait_start(10);
            check("rr_grant", grant_id, exp_g[r]);
            run_brew(4'b0000, (r == 0) ? 4'b0001 : 4'b0000, exp_p[r]);
            check("rr_done", done, 4'b0001 << exp_g[r]);
            @(negedge clk);
            check("rr_done_gone", done, 0);
        end
        check("rr_cups", cups_served, 4);
        check("rr_sat_cups", sat_cups, 3);
        check("rr_pending", pending, 0);
        pulse_req(4'b0100);
        wait_start(5);
        check("fifth_grant", grant_id, 2);
        run_brew(4'b0000, 4'b0000, 4'b0000);
        check("fifth_done", done, 4'b0100);
        @(negedge clk);
        check("fifth_cups", cups_served, 5);
        check("fifth_sat_cups", sat_cups, 3);

        // Ack timeout: machine never leaves IDLE
        apply_reset();
        pulse_req(4'b0100);
        wait_start(5);
        repeat (15) @(negedge clk);
        check("ack_last_cycle_err", error, 0);
        check("ack_last_cycle_start", start, 1);
        @(negedge clk);
        check("ack_timeout_err", error, 1);
        check("ack_timeout_start", start, 0);
        check("ack_timeout_pending", pending, 4'b0100);
        repeat (3) @(negedge clk);
        check("ack_err_sticky", error, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("ack_cleared", error, 0);
        check("ack_cleared_busy", busy, 0);
        wait_start(5);
        check("ack_retry_grant", grant_id, 2);
        run_brew(4'b0000, 4'b0000, 4'b0000);
        check("ack_retry_done", done, 4'b0100);
        @(negedge clk);
        check("ack_retry_cups", cups_served, 1);

        // Brew timeout: machine stuck in state 5
        apply_reset();
        pulse_req(4'b0001);
        wait_start(5);
        machine_state = 4'd5;
        done_seen     = '0;
        @(negedge clk);
        check("brew_pending_cleared", pending, 0);
        repeat (254) begin
            @(negedge clk);
            done_seen |= done;
        end
        check("brew_last_cycle_err", error, 0);
        check("brew_last_cycle_busy", busy, 1);
        @(negedge clk);
        done_seen |= done;
        check("brew_timeout_err", error, 1);
        check("brew_timeout_pending", pending, 0);
        check("brew_no_done", done_seen, 0);
        machine_state = 4'd1;
        clear_err     = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("brew_cleared", error, 0);
        check("brew_cups", cups_served, 0);
        check("brew_idle", busy, 0);

        // Re-order on the acceptance edge, then served again
        apply_reset();
        pulse_req(4'b0010);
        wait_start(5);
        check("reorder_grant", grant_id, 1);
        run_brew(4'b0010, 4'b0000, 4'b0010);
        check("reorder_done1", done, 4'b0010);
        wait_start(5);
        check("reorder_grant2", grant_id, 1);
        run_brew(4'b0000, 4'b0000, 4'b0000);
        check("reorder_done2", done, 4'b0010);
        @(negedge clk);
        check("reorder_cups", cups_served, 2);

        // Async reset in the middle of a brew
        pulse_req(4'b1000);
        wait_start(5);
        machine_state = 4'd2;
        @(negedge clk);
        machine_state = 4'd3;
        req           = 4'b0001;
        @(negedge clk);
        req = '0;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_pending", pending, 4'b0001);
        check("pre_reset_cups", cups_served, 2);
        #1;
        rst_n         = 1'b0;
        machine_state = 4'd1;
        #1;
        check("async_busy", busy, 0);
        check("async_start", start, 0);
        check("async_pending", pending, 0);
        check("async_cups", cups_served, 0);
        check("async_grant", grant_id, 0);
        check("async_error", error, 0);
        check("async_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
